// File: rtl/avalon_burst_responder.sv
// Avalon-MM bursting slave: word-addressed 32-bit register RAM plus a doorbell event source.
//
// Ports:
//   iCLK, iRESET        clock, synchronous active-high reset
//   iADDRESS            word address; only [ADDR_WIDTH-1:0] used, upper bits alias
//   iWRITE/iWRITE_DATA  write beat request and data
//   iREAD               read command request
//   iBURST_COUNT        beats per burst (0 treated as 1, values above 16 clamp to 16)
//   oWAIT_REQUEST       stall; a request is taken only when low
//   oREAD_DATA(_VALID)  read beats, READ_LATENCY cycles after issue, back to back
//   oEVENT_WRITE(_DATA) one-cycle event push toward the bridge
//   iEVENT_EMPTY        consumer event slot free
//
// READ_LATENCY legal range is 1..4.
module avalon_burst_responder #(
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned DOORBELL_ADDR = (1 << ADDR_WIDTH) - 1
) (
  input  logic        iCLK,
  input  logic        iRESET,
  input  logic [31:0] iADDRESS,
  input  logic        iWRITE,
  input  logic        iREAD,
  input  logic [31:0] iWRITE_DATA,
  input  logic [4:0]  iBURST_COUNT,
  output logic        oWAIT_REQUEST,
  output logic [31:0] oREAD_DATA,
  output logic        oREAD_DATA_VALID,
  output logic        oEVENT_WRITE,
  output logic [31:0] oEVENT_WRITE_DATA,
  input  logic        iEVENT_EMPTY
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] idx_t;

  localparam idx_t DbIdx = idx_t'(DOORBELL_ADDR);

  typedef enum logic [1:0] {StIdle, StWrBurst, StRdBurst} state_e;

  // Storage
  logic [31:0] mem_q [Depth];

  // Control state
  state_e      state_q, state_d;
  idx_t        base_q, base_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  k_q, k_d;

  // Doorbell / event state
  logic        pending_q, pending_d;
  logic [31:0] evt_q, evt_d;
  logic        ev_wr_q, ev_wr_d;
  logic [31:0] ev_data_q, ev_data_d;

  // Read pipeline, stage READ_LATENCY-1 drives the outputs
  logic        vld_q  [READ_LATENCY];
  logic        last_q [READ_LATENCY];
  logic [31:0] dat_q  [READ_LATENCY];

  // Combinational helpers
  logic [4:0]  n_in;
  idx_t        in_idx;
  idx_t        burst_idx;
  idx_t        wr_idx;
  idx_t        rd_idx;
  logic        db_stall;
  logic        out_last;
  logic        cmd_ready;
  logic        wr_acc;
  logic        rd_issue;
  logic        rd_last;
  logic        wait_req;

  logic unused_addr;
  assign unused_addr = ^iADDRESS[31:ADDR_WIDTH];

  always_comb begin
    if (iBURST_COUNT == 5'd0) begin
      n_in = 5'd1;
    end else if (iBURST_COUNT > 5'd16) begin
      n_in = 5'd16;
    end else begin
      n_in = iBURST_COUNT;
    end
  end

  assign in_idx    = iADDRESS[ADDR_WIDTH-1:0];
  assign burst_idx = base_q + idx_t'(k_q);
  assign wr_idx    = (state_q == StWrBurst) ? burst_idx : in_idx;
  // A second doorbell beat may not overwrite an event the consumer has not taken yet.
  assign db_stall  = pending_q && (wr_idx == DbIdx);
  assign out_last  = vld_q[READ_LATENCY-1] && last_q[READ_LATENCY-1];
  // A new command may be taken in IDLE or in the cycle the last read beat is presented.
  assign cmd_ready = (state_q == StIdle) || ((state_q == StRdBurst) && out_last);

  // Next-state and request handling
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    wait_req = 1'b0;
    wr_acc   = 1'b0;
    rd_issue = 1'b0;
    rd_idx   = in_idx;
    rd_last  = 1'b0;

    if (iRESET) begin
      wait_req = 1'b1;
    end else if (cmd_ready) begin
      state_d = StIdle;
      if (iWRITE) begin
        // Write wins over a simultaneous read; the read sees the stall this cycle.
        wait_req = db_stall || iREAD;
        if (!db_stall) begin
          wr_acc = 1'b1;
          if (n_in > 5'd1) begin
            state_d = StWrBurst;
            base_d  = in_idx;
            cnt_d   = n_in;
            k_d     = 5'd1;
          end
        end
      end else if (iREAD) begin
        // Beat 0 is issued in the acceptance cycle so it lands READ_LATENCY cycles later.
        rd_issue = 1'b1;
        rd_idx   = in_idx;
        rd_last  = (n_in == 5'd1);
        state_d  = StRdBurst;
        base_d   = in_idx;
        cnt_d    = n_in;
        k_d      = 5'd1;
      end
    end else begin
      unique case (state_q)
        StWrBurst: begin
          if (iWRITE) begin
            if (db_stall) begin
              wait_req = 1'b1;
            end else begin
              wr_acc = 1'b1;
              k_d    = k_q + 5'd1;
              if (k_q == cnt_q - 5'd1) begin
                state_d = StIdle;
              end
            end
          end
        end
        StRdBurst: begin
          wait_req = 1'b1;
          if (k_q < cnt_q) begin
            rd_issue = 1'b1;
            rd_idx   = burst_idx;
            rd_last  = (k_q == cnt_q - 5'd1);
            k_d      = k_q + 5'd1;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Doorbell capture and event push
  always_comb begin
    pending_d = pending_q;
    evt_d     = evt_q;
    ev_wr_d   = 1'b0;
    ev_data_d = ev_data_q;
    if (wr_acc && (wr_idx == DbIdx)) begin
      // Only reachable with pending_q low, so this never collides with a push.
      pending_d = 1'b1;
      evt_d     = iWRITE_DATA;
    end else if (pending_q && iEVENT_EMPTY) begin
      pending_d = 1'b0;
      ev_wr_d   = 1'b1;
      ev_data_d = evt_q;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q   <= StIdle;
      base_q    <= '0;
      cnt_q     <= '0;
      k_q       <= '0;
      pending_q <= 1'b0;
      evt_q     <= '0;
      ev_wr_q   <= 1'b0;
      ev_data_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      pending_q <= pending_d;
      evt_q     <= evt_d;
      ev_wr_q   <= ev_wr_d;
      ev_data_q <= ev_data_d;
    end
  end

  // RAM contents survive reset; wr_acc is already held low during reset.
  always_ff @(posedge iCLK) begin
    if (wr_acc) begin
      mem_q[wr_idx] <= iWRITE_DATA;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        vld_q[i]  <= 1'b0;
        last_q[i] <= 1'b0;
        dat_q[i]  <= '0;
      end
    end else begin
      vld_q[0]  <= rd_issue;
      last_q[0] <= rd_last;
      dat_q[0]  <= mem_q[rd_idx];
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        last_q[i] <= last_q[i-1];
        dat_q[i]  <= dat_q[i-1];
      end
    end
  end

  assign oWAIT_REQUEST     = wait_req;
  assign oREAD_DATA        = dat_q[READ_LATENCY-1];
  assign oREAD_DATA_VALID  = vld_q[READ_LATENCY-1];
  assign oEVENT_WRITE      = ev_wr_q;
  assign oEVENT_WRITE_DATA = ev_data_q;

endmodule

// File: doc/avalon_burst_responder.md
Name: avalon_burst_responder

Overview:
- Avalon-MM bursting slave: a word-addressed on-chip register RAM plus a doorbell event source.
- Sits at the far end of the virtual-JTAG bridge's Avalon master port.
- Serves single and burst reads and writes from the bridge.
- Turns writes to a doorbell word into event pushes, through the bridge's event input, back toward the JTAG host.

Parameters:
- ADDR_WIDTH, 8: RAM index width; depth is 2^ADDR_WIDTH 32-bit words.
- READ_LATENCY, 2: cycles from read command acceptance to the first oREAD_DATA_VALID; legal range 1..4.
- DOORBELL_ADDR, 2^ADDR_WIDTH-1: RAM index of the doorbell word.

Ports:
- iCLK  in  1  system clock.
- iRESET  in  1  synchronous, active-high reset.
- iADDRESS  in  32  word address; only bits [ADDR_WIDTH-1:0] are used, upper bits alias.
- iWRITE  in  1  write beat request.
- iREAD  in  1  read command request.
- iWRITE_DATA  in  32  write beat data.
- iBURST_COUNT  in  5  beats in the burst; 0 is treated as 1; maximum 16.
- oWAIT_REQUEST  out  1  stall; a request is accepted only in a cycle where this is low.
- oREAD_DATA  out  32  read beat data.
- oREAD_DATA_VALID  out  1  read beat qualifier.
- oEVENT_WRITE  out  1  one-cycle event push.
- oEVENT_WRITE_DATA  out  32  event payload.
- iEVENT_EMPTY  in  1  high when the consumer's event slot is free.

Behaviour:
- Reset (iRESET sampled high on an iCLK edge):
  - Outputs: oWAIT_REQUEST=1, oREAD_DATA_VALID=0, oREAD_DATA=0, oEVENT_WRITE=0, oEVENT_WRITE_DATA=0.
  - State goes to IDLE. Any pending event is dropped. The read pipeline is flushed. Remaining burst beats are abandoned.
  - RAM contents are retained.
  - oWAIT_REQUEST drops to 0 in the first cycle after iRESET deasserts.
- States: IDLE, WRBURST, RDBURST.
- IDLE:
  - oWAIT_REQUEST=0.
  - If iWRITE and iREAD are both high, the write wins and the read is stalled: oWAIT_REQUEST=1 toward the read in that cycle.
  - Accepted iWRITE:
    - Writes beat 0 at iADDRESS.
    - Latches base index and count N.
    - If N>1, moves to WRBURST with beat counter k=1.
  - Accepted iREAD:
    - Latches base index and N.
    - Moves to RDBURST.
- WRBURST:
  - oWAIT_REQUEST=0, except for doorbell stalls (below).
  - Each cycle with iWRITE high writes beat k at base+k; the index wraps modulo 2^ADDR_WIDTH.
  - iADDRESS and iBURST_COUNT are ignored on beats after the first.
  - Idle cycles (iWRITE low) are allowed and do not advance k.
  - iREAD is ignored.
  - Returns to IDLE in the cycle the beat with k=N-1 is accepted.
- RDBURST:
  - oWAIT_REQUEST=1.
  - Issues one RAM read per cycle at base+k for k=0..N-1, with wrap-around as for writes.
  - Each read flows through a READ_LATENCY-deep valid/data pipeline.
  - If the command is accepted at cycle T, beat k has oREAD_DATA_VALID=1 at T+READ_LATENCY+k. Beats are back-to-back with no gaps.
  - oWAIT_REQUEST returns low in the same cycle the last beat's valid is presented. A new command accepted then produces its first valid READ_LATENCY cycles later.
  - oREAD_DATA is don't-care when valid is low; the bench must not check it.
- Read/write ordering: a read at an index written in the immediately preceding accepted beat returns the new data (write-before-read).
- Doorbell:
  - A write beat whose index equals DOORBELL_ADDR stores its data in an event register and sets event_pending. It also updates the RAM word, so reads return the last doorbell value.
  - While event_pending=1 and iEVENT_EMPTY=1: pulse oEVENT_WRITE=1 for exactly one cycle with oEVENT_WRITE_DATA set to the event register, then clear event_pending.
    - The push cycle is the cycle after the doorbell beat at the earliest.
    - oEVENT_WRITE_DATA holds its value after the pulse.
  - A doorbell write beat arriving while event_pending=1 is stalled: oWAIT_REQUEST=1 for that beat until the pending push completes. No event is overwritten or lost.
  - If iEVENT_EMPTY stays low, the stall persists indefinitely. This is the required behaviour.
- Width and arithmetic:
  - The beat counter is 5 bits; N ranges 1..16.
  - The index adder is ADDR_WIDTH bits and wraps.

Test Plan:
- Reset, then write 0xDEADBEEF at address 0x10 with N=1; read 0x10 with N=1 → one valid beat carrying 0xDEADBEEF at T+2; oWAIT_REQUEST low again in that cycle.
- Write burst N=4 at base 0xFE with data 1..4, one idle cycle between beats 2 and 3; read burst N=4 at 0xFE → RAM 0xFE=1, 0xFF=2 (doorbell, event 2 pushed), 0x00=3, 0x01=4; read beats 1,2,3,4 on consecutive cycles T+2..T+5.
- iBURST_COUNT=0 on a read at 0x20 → exactly one valid beat.
- Doorbell write 0xA5A5A5A5 with iEVENT_EMPTY=0, then a second doorbell write 0x5A5A5A5A → second beat stalled; raise iEVENT_EMPTY → oEVENT_WRITE pulses with 0xA5A5A5A5; second beat then accepted; next push carries 0x5A5A5A5A.
- Assert iRESET at beat 3 of a 16-beat read → oREAD_DATA_VALID=0 from the reset cycle on, no further beats; oWAIT_REQUEST=1 during reset, 0 after; a new read returns correct data.
- iWRITE and iREAD asserted together in IDLE → write accepted; read held by oWAIT_REQUEST=1 for that cycle and accepted the next cycle.
